// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Horizontal and vertical counters walk the frame. The visible-pixel request
// and the line/frame pulses come straight from the counters. hsync, vsync,
// blank_n, sync_n and the colour gate pass through a PIX_LAT-deep pipeline so
// that they line up with colour_in coming back from the pixel source.
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   en              pixel-clock enable; all state advances only when high
//   colour_in       {R,G,B} for the pixel requested PIX_LAT enabled cycles ago
//   x_pixel/y_pixel raw h/v counters
//   pix_req         current (x,y) lies in the visible area
//   hsync/vsync     delayed syncs at HS_POL/VS_POL when asserted
//   red/green/blue  gated colour, zero outside the delayed visible area
//   blank_n         delayed pix_req
//   sync_n          delayed composite sync, active-low
//   line_start      en && h==0
//   frame_start     en && h==0 && v==0
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned CW       = 8,
  parameter int unsigned PIX_LAT  = 1,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [3*CW-1:0] colour_in,
  output logic [XW-1:0]   x_pixel,
  output logic [YW-1:0]   y_pixel,
  output logic            pix_req,
  output logic            hsync,
  output logic            vsync,
  output logic [CW-1:0]   red,
  output logic [CW-1:0]   green,
  output logic [CW-1:0]   blue,
  output logic            blank_n,
  output logic            sync_n,
  output logic            line_start,
  output logic            frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] H_FP_START   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_SYNC_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_BP_START   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW-1:0] H_LAST       = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_FP_START   = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_SYNC_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_BP_START   = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [YW-1:0] V_LAST       = YW'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FP,
    REG_SYNC,
    REG_BP
  } region_e;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
    logic sync_n;
  } stage_t;

  localparam stage_t STAGE_BLANK = '{hs: ~HS_POL, vs: ~VS_POL, vis: 1'b0, sync_n: 1'b1};

  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;
  region_e       h_region, v_region;
  stage_t        raw, del;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    h_region = REG_BP;
    if      (h_q < H_FP_START)   h_region = REG_ACTIVE;
    else if (h_q < H_SYNC_START) h_region = REG_FP;
    else if (h_q < H_BP_START)   h_region = REG_SYNC;
  end

  always_comb begin
    v_region = REG_BP;
    if      (v_q < V_FP_START)   v_region = REG_ACTIVE;
    else if (v_q < V_SYNC_START) v_region = REG_FP;
    else if (v_q < V_BP_START)   v_region = REG_SYNC;
  end

  always_comb begin
    raw.hs     = (h_region == REG_SYNC) ? HS_POL : ~HS_POL;
    raw.vs     = (v_region == REG_SYNC) ? VS_POL : ~VS_POL;
    raw.vis    = (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);
    raw.sync_n = !((h_region == REG_SYNC) || (v_region == REG_SYNC));
  end

  generate
    if (PIX_LAT == 0) begin : g_nolat
      always_comb del = raw;
    end else begin : g_pipe
      stage_t pipe_q [PIX_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < PIX_LAT; i++) pipe_q[i] <= STAGE_BLANK;
        end else if (en) begin
          pipe_q[0] <= raw;
          for (int unsigned i = 1; i < PIX_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      always_comb del = pipe_q[PIX_LAT-1];
    end
  endgenerate

  always_comb begin
    x_pixel     = h_q;
    y_pixel     = v_q;
    pix_req     = raw.vis;
    line_start  = en && (h_q == '0);
    frame_start = en && (h_q == '0) && (v_q == '0);
    hsync       = del.hs;
    vsync       = del.vs;
    blank_n     = del.vis;
    sync_n      = del.sync_n;
    // Colour arrives already aligned with the delayed stage; only the gate is registered.
    red         = del.vis ? colour_in[3*CW-1:2*CW] : '0;
    green       = del.vis ? colour_in[2*CW-1:CW]   : '0;
    blue        = del.vis ? colour_in[CW-1:0]      : '0;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL declare these parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- HS_POL, 0, asserted level of hsync
- VS_POL, 0, asserted level of vsync
- CW, 8, bits per colour channel
- PIX_LAT, 1, cycles from pix_req/x/y to valid colour_in, range 0..4
- XW/YW, 10/10, coordinate widths; must cover H_TOTAL-1 and V_TOTAL-1

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock
- rst, in, 1, synchronous active-high reset
- en, in, 1, pixel-clock enable; the design advances only on clk edges with en=1
- colour_in, in, 3*CW, {R,G,B} for the pixel requested PIX_LAT enabled cycles earlier
- x_pixel, out, XW, horizontal counter
- y_pixel, out, YW, vertical counter
- pix_req, out, 1, current (x,y) is visible
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- red / green / blue, out, CW each, colour outputs
- blank_n, out, 1, low during blanking
- sync_n, out, 1, composite sync, active-low
- line_start, out, 1, one-enabled-cycle pulse
- frame_start, out, 1, one-enabled-cycle pulse

Function
REQ-003 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-004 The h counter SHALL increment on each enabled cycle and wrap from H_TOTAL-1 to 0; on wrap, the v counter SHALL increment and wrap from V_TOTAL-1 to 0.
REQ-005 Horizontal state SHALL be ACTIVE for h in [0,H_ACTIVE), FRONT_PORCH for the next H_FP counts, SYNC for the next H_SYNC counts, and BACK_PORCH for the remainder; vertical state SHALL follow the same scheme on v.
REQ-006 x_pixel and y_pixel SHALL equal the raw h and v counters, undelayed.
REQ-007 pix_req SHALL be 1 iff both the horizontal and vertical states are ACTIVE, undelayed.
REQ-008 line_start SHALL be 1 when h==0 and en=1; frame_start SHALL be 1 when h==0, v==0 and en=1; both are undelayed.
REQ-009 hsync, vsync, blank_n, sync_n and the colour gate SHALL be delayed by exactly PIX_LAT enabled cycles through a shift pipeline that advances only when en=1. With PIX_LAT=0, they are combinational from the counters.
REQ-010 hsync SHALL be HS_POL during the delayed H SYNC state and ~HS_POL otherwise; vsync SHALL follow the same rule with VS_POL.
REQ-011 sync_n SHALL be 0 iff the delayed H SYNC or the delayed V SYNC state is asserted, regardless of polarity parameters.
REQ-012 blank_n SHALL equal the delayed pix_req.
- red/green/blue SHALL be colour_in[3CW-1:2CW], [2CW-1:CW] and [CW-1:0] when the delayed pix_req=1, else 0.
- All outputs are registered, except under PIX_LAT=0.
REQ-013 With en=0, all counters and pipeline stages SHALL hold; line_start and frame_start SHALL be 0.
REQ-014 Every output other than red/green/blue SHALL be a registered or counter-derived value, with no glitch-prone logic between registers and output ports.

Reset
REQ-015 While rst=1 at a clk edge, regardless of en: h=v=0 and all pipeline stages SHALL be loaded with the blanking value (hsync=~HS_POL, vsync=~VS_POL, blank_n=0, sync_n=1, colour gate 0).
REQ-016 After reset, outputs SHALL read: x=y=0, pix_req=1, RGB=0, blank_n=0 (PIX_LAT>0), frame_start=en.
REQ-017 Reset asserted mid-frame SHALL abandon the frame; the first enabled cycle after release SHALL be h=0, v=0 with frame_start=1.

Verification
REQ-018 Defaults, en=1 held, run 420000 cycles -> exactly one frame_start every 420000 cycles and 525 line_start pulses per frame.
REQ-019 Defaults, PIX_LAT=1 -> hsync=0 for delayed h in 656..751 (96 cycles per line); vsync=0 for v in 490..491; sync_n=0 whenever either is asserted.
REQ-020 colour_in driven with {x[7:0],y[7:0],8'hA5} delayed one cycle, PIX_LAT=1 -> at pixel (5,3) red=5, green=3, blue=A5; during h=700, RGB=0 and blank_n=0.
REQ-021 en toggling 1,0,1,0… -> counters advance every other clk; frame period is 840000 clk; no pulse appears while en=0.
REQ-022 rst pulsed for 1 cycle at h=300, v=200 -> next cycle x=0, y=0, frame_start=1, hsync=1, blank_n=0.
REQ-023 Parameter set H=4/1/1/1, V=2/1/1/1, HS_POL=1, VS_POL=1, PIX_LAT=0 -> H_TOTAL=7, V_TOTAL=5; hsync=1 only at h=5; vsync=1 only on line v=3.
